cube_scan: RTL and testbench
============================

# cube_scan

Display driver that sits directly downstream of `conway_sim` and consumes its 512-bit `Cells` vector (an 8×8×8 cube). It scans the cube one layer at a time. Each layer's 64 cells are shifted into an external chain of serial-in/parallel-out LED drivers, then latched. The matching layer transistor is then enabled for a fixed dwell time. A whole-cube snapshot is taken at every frame start, so a generation update never tears a displayed frame.

## Interface
Parameters:
- `CLK_DIV`, default 4: system cycles per half period of `Ser_clk`; must be ≥1.
- `DWELL`, default 1000: cycles each layer stays lit; must be ≥1.

Ports:
- `Clk` input 1: system clock; all logic is on the rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `Cells` input 512: cube state; cell (x,y,z) is `Cells[z*64 + y*8 + x]`.
- `Blank` input 1: when high, forces the display dark; scanning continues.
- `Ser_data` output 1: serial data to the driver chain.
- `Ser_clk` output 1: shift clock to the driver chain.
- `Ser_latch` output 1: storage-register latch strobe.
- `Ser_oe_n` output 1: driver output enable, active-low.
- `Layer_en` output 8: one-hot layer select.
- `Frame_done` output 1: one-cycle pulse at the end of each frame.

## Operation
- Single clock domain, and all outputs are registered.
- Reset values: `Ser_data`=0, `Ser_clk`=0, `Ser_latch`=0, `Ser_oe_n`=1, `Layer_en`=8'h00, `Frame_done`=0. Internally, layer index z=0 and the FSM is in LOAD.
- FSM states:
  - **LOAD (1 cycle):**
    - If z==0, copy `Cells` into a 512-bit frame buffer.
    - Load a 64-bit shift register with frame buffer bits `[z*64+63 : z*64]`.
    - Set bit count to 64, force `Layer_en`=0 and `Ser_oe_n`=1.
    - Go to SHIFT.
  - **SHIFT:**
    - Each bit occupies 2·CLK_DIV cycles.
    - `Ser_data` presents the current MSB of the shift register and is stable for the whole bit period.
    - `Ser_clk` is 0 for the first CLK_DIV cycles of the bit and 1 for the last CLK_DIV cycles.
    - Bit order is highest index first, so `Cells[z*64+63]` goes out first and `Cells[z*64]` goes out last.
    - After 64 bits, `Ser_clk` returns to 0 and the FSM goes to LATCH.
  - **LATCH:**
    - `Ser_latch`=1 for CLK_DIV cycles, then 0.
    - Go to DWELL.
  - **DWELL:**
    - `Layer_en` = 1<<z and `Ser_oe_n`=0 for DWELL cycles.
    - On exit: if z==7, pulse `Frame_done` and wrap z to 0; otherwise z increments.
    - Then return to LOAD.
- Blanking (`Layer_en`=0, `Ser_oe_n`=1) holds in every state except DWELL, which prevents ghosting while new data shifts in.
- `Blank`=1 forces `Layer_en`=0 and `Ser_oe_n`=1 from the next cycle onward. FSM timing and z are unaffected. When `Blank` is released mid-DWELL, the layer re-lights on the next cycle.
- `Cells` changes between frame starts are ignored until the next LOAD with z==0.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronously), and the in-flight frame is discarded. After release, the first LOAD (z==0, fresh snapshot) happens on the first rising edge.

## Timing
- Cycles per layer: 1 + 128·CLK_DIV + CLK_DIV + DWELL. With defaults this is 1 + 512 + 4 + 1000 = 1517.
- Cycles per frame: 8 × per-layer, which is 12136 with defaults.
- Snapshot-to-light latency for layer 0: 1 + 129·CLK_DIV cycles, which is 517 with defaults.
- `Frame_done` is high for exactly 1 cycle. It coincides with the cycle in which the FSM re-enters LOAD for z=0.
- Exactly 64 `Ser_clk` rising edges and 1 `Ser_latch` pulse per layer.

## Test plan
- **Reset values:** hold `Reset`=0 for 5 cycles. Every output equals its reset value, including `Ser_oe_n`=1 and `Layer_en`=8'h00.
- **Single cell:** `Cells`=512'h1, defaults. In layer 0, `Ser_data` is sampled at each `Ser_clk` rise; bits 1–63 read 0 and the 64th bit reads 1. `Layer_en`=8'h01 during DWELL. Layers 1–7 shift all zeros.
- **Counting and timing:** `Cells` = alternating 0xAA… pattern. Per layer, the bench sees 64 `Ser_clk` rises and 1 latch pulse lasting 4 cycles. Layer period is 1517 cycles. `Frame_done` pulses every 12136 cycles, and `Layer_en` steps 01→02→…→80→01.
- **Snapshot integrity:** change `Cells` from all-0 to all-1 while layer 3 is in SHIFT. Layers 3–7 of that frame still shift zeros. The next frame shifts all ones.
- **Blank:** assert `Blank` mid-DWELL of layer 2. `Layer_en`=0 and `Ser_oe_n`=1 from the next cycle. `Frame_done` timing is unchanged. Releasing `Blank` restores `Layer_en`=8'h04 within that same dwell.
- **Reset mid-operation:** pulse `Reset` low during the SHIFT of layer 5. Outputs go to their reset values immediately. After release, the next `Layer_en` assertion is 8'h01, lit 517 cycles after release.

Source files
------------

// File: rtl/cube_scan_if.sv
// Signal bundle between the Conway cube source, the scan driver and the LED driver chain.
interface cube_scan_if;
  logic [511:0] Cells;
  logic         Blank;
  logic         Ser_data;
  logic         Ser_clk;
  logic         Ser_latch;
  logic         Ser_oe_n;
  logic [7:0]   Layer_en;
  logic         Frame_done;

  modport slave (
    input  Cells, Blank,
    output Ser_data, Ser_clk, Ser_latch, Ser_oe_n, Layer_en, Frame_done
  );

  modport master (
    output Cells, Blank,
    input  Ser_data, Ser_clk, Ser_latch, Ser_oe_n, Layer_en, Frame_done
  );
endinterface

// File: rtl/cube_scan.sv
// Layer-multiplexed 8x8x8 LED cube scanner: snapshots the cube per frame, shifts each
// 64-cell layer into a SIPO driver chain, latches it, then lights that layer for DWELL cycles.
module cube_scan #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DWELL   = 1000
) (
  input  logic        Clk,
  input  logic        Reset,
  cube_scan_if.slave  bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DWL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_DWELL = 2'd3;

  logic [1:0]       state;
  logic [2:0]       z;
  logic [511:0]     frame;
  logic [63:0]      shreg;
  logic [6:0]       bits_left;
  logic [DIV_W-1:0] div_cnt;
  logic [DWL_W-1:0] dwell_cnt;

  logic             ser_data;
  logic             ser_clk;
  logic             ser_latch;
  logic             oe_n;
  logic [7:0]       layer_en;
  logic             frame_done;

  logic [63:0]      layer_src;
  logic [7:0]       lit_en;
  logic             div_end;

  // Layer 0 reads the live input so the snapshot and its first shift load share one cycle.
  always_comb begin
    layer_src = (z == 3'd0) ? bus.Cells[63:0] : frame[{z, 6'd0} +: 64];
    lit_en    = 8'b1 << z;
    div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_LOAD;
      z          <= '0;
      frame      <= '0;
      shreg      <= '0;
      bits_left  <= '0;
      div_cnt    <= '0;
      dwell_cnt  <= '0;
      ser_data   <= 1'b0;
      ser_clk    <= 1'b0;
      ser_latch  <= 1'b0;
      oe_n       <= 1'b1;
      layer_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_LOAD: begin
          if (z == 3'd0) frame <= bus.Cells;
          shreg     <= layer_src;
          ser_data  <= layer_src[63];
          ser_clk   <= 1'b0;
          div_cnt   <= '0;
          bits_left <= 7'd64;
          layer_en  <= '0;
          oe_n      <= 1'b1;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!ser_clk) begin
              ser_clk <= 1'b1;
            end else begin
              // Falling half done: advance to the next bit so data changes with Ser_clk low.
              ser_clk   <= 1'b0;
              shreg     <= {shreg[62:0], 1'b0};
              ser_data  <= shreg[62];
              bits_left <= bits_left - 1'b1;
              if (bits_left == 7'd1) begin
                state     <= S_LATCH;
                ser_latch <= 1'b1;
              end
            end
          end
        end
        S_LATCH: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt   <= '0;
            ser_latch <= 1'b0;
            dwell_cnt <= '0;
            layer_en  <= bus.Blank ? '0 : lit_en;
            oe_n      <= bus.Blank;
            state     <= S_DWELL;
          end
        end
        S_DWELL: begin
          if (dwell_cnt != DWL_W'(DWELL - 1)) begin
            dwell_cnt <= dwell_cnt + 1'b1;
            layer_en  <= bus.Blank ? '0 : lit_en;
            oe_n      <= bus.Blank;
          end else begin
            layer_en   <= '0;
            oe_n       <= 1'b1;
            frame_done <= (z == 3'd7);
            z          <= z + 3'd1;
            state      <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign bus.Ser_data   = ser_data;
  assign bus.Ser_clk    = ser_clk;
  assign bus.Ser_latch  = ser_latch;
  assign bus.Ser_oe_n   = oe_n;
  assign bus.Layer_en   = layer_en;
  assign bus.Frame_done = frame_done;

endmodule

// File: tb/tb_cube_scan.sv
// Scoreboard bench for cube_scan: each frame's expected layers are queued at snapshot time
// and a monitor compares what the driver chain receives when each latch strobe completes.
module tb_cube_scan;

  localparam int C     = 2;
  localparam int D     = 40;
  localparam int LIGHT = 1 + 129 * C;
  localparam int LAYER = 1 + 128 * C + C + D;
  localparam int FRAME = 8 * LAYER;

  typedef struct {
    int          z;
    logic [63:0] bits;
  } layer_rec_t;

  logic Clk;
  logic Reset;
  cube_scan_if bus ();

  cube_scan #(.CLK_DIV(C), .DWELL(D)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;
  layer_rec_t exp_q[$];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [511:0] rand_cells();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic push_frame(input logic [511:0] v);
    layer_rec_t r;
    for (int zz = 0; zz < 8; zz++) begin
      r.z    = zz;
      r.bits = v[zz*64 +: 64];
      exp_q.push_back(r);
    end
  endtask

  // Entered at the negedge before a frame's snapshot edge; k counts edges into the frame.
  task automatic run_frame(input logic [511:0] v, input logic [511:0] v2, input int change_at,
                           input int blank_at, input int reset_at, output bit did_reset);
    did_reset = 1'b0;
    bus.Cells = v;
    push_frame(v);
    for (int k = 0; k < FRAME; k++) begin
      if (k == change_at) bus.Cells = v2;
      if (k == blank_at) bus.Blank = 1'b1;
      if (blank_at >= 0 && k == blank_at + 1) begin
        check("blank_layer_en", 64'(bus.Layer_en), 64'h0);
        check("blank_oe_n", 64'(bus.Ser_oe_n), 64'h1);
      end
      if (blank_at >= 0 && k == blank_at + 10) bus.Blank = 1'b0;
      if (blank_at >= 0 && k == blank_at + 11) begin
        check("unblank_layer_en", 64'(bus.Layer_en), 64'h04);
        check("unblank_oe_n", 64'(bus.Ser_oe_n), 64'h0);
      end
      if (k == reset_at) begin
        Reset = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({bus.Ser_data, bus.Ser_clk, bus.Ser_latch, bus.Ser_oe_n, bus.Layer_en, bus.Frame_done}),
              64'({1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}));
        did_reset = 1'b1;
        return;
      end
      @(negedge Clk);
    end
  endtask

  // Monitor: tracks the serial stream and compares each completed layer against the queue.
  int          cyc;
  int          rises;
  int          latch_len;
  logic [63:0] got_bits;
  logic        prev_clk, prev_latch, prev_fd;
  logic        await_light;
  logic [7:0]  exp_en, last_en;

  always begin
    layer_rec_t r;
    @(posedge Clk);
    #1;
    if (!Reset) begin
      cyc = 0; rises = 0; latch_len = 0; got_bits = '0;
      prev_clk = 1'b0; prev_latch = 1'b0; prev_fd = 1'b0;
      await_light = 1'b0; exp_en = '0; last_en = '0;
    end else begin
      cyc++;
      if (bus.Ser_clk && !prev_clk) begin
        got_bits = {got_bits[62:0], bus.Ser_data};
        rises++;
      end
      prev_clk = bus.Ser_clk;
      if (bus.Ser_latch) latch_len++;
      if (!bus.Ser_latch && prev_latch) begin
        check("layer_period", 64'((cyc - LIGHT) % LAYER), 64'h0);
        check("ser_clk_rises", 64'(rises), 64'd64);
        check("latch_width", 64'(latch_len), 64'(C));
        if (exp_q.size() == 0) begin
          check("unexpected_layer", 64'h1, 64'h0);
          exp_en = '0;
        end else begin
          r = exp_q.pop_front();
          check($sformatf("layer%0d_bits", r.z), got_bits, r.bits);
          exp_en = 8'(1 << r.z);
        end
        rises = 0; latch_len = 0; got_bits = '0;
        await_light = 1'b1;
      end
      prev_latch = bus.Ser_latch;
      if (await_light && bus.Layer_en != 8'h00) begin
        check("layer_en", 64'(bus.Layer_en), 64'(exp_en));
        check("oe_n_lit", 64'(bus.Ser_oe_n), 64'h0);
        last_en     = bus.Layer_en;
        await_light = 1'b0;
      end
      if (bus.Frame_done) begin
        check("frame_done_timing", 64'(cyc % FRAME), 64'h0);
        check("frame_done_width", 64'(prev_fd), 64'h0);
        check("frame_done_last_layer", 64'(last_en), 64'h80);
      end
      prev_fd = bus.Frame_done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit           rst_hit;
    int           n;
    logic [511:0] v;
    Reset     = 1'b0;
    bus.Cells = '0;
    bus.Blank = 1'b0;
    repeat (5) @(negedge Clk);
    check("reset_ser_data", 64'(bus.Ser_data), 64'h0);
    check("reset_ser_clk", 64'(bus.Ser_clk), 64'h0);
    check("reset_ser_latch", 64'(bus.Ser_latch), 64'h0);
    check("reset_oe_n", 64'(bus.Ser_oe_n), 64'h1);
    check("reset_layer_en", 64'(bus.Layer_en), 64'h0);
    check("reset_frame_done", 64'(bus.Frame_done), 64'h0);

    Reset = 1'b1;
    run_frame(512'h1, '0, -1, -1, -1, rst_hit);
    run_frame({64{8'hAA}}, '0, -1, -1, -1, rst_hit);
    run_frame('0, '1, 3 * LAYER + 20, -1, -1, rst_hit);
    run_frame('1, '0, -1, -1, -1, rst_hit);
    run_frame(rand_cells(), '0, -1, 2 * LAYER + LIGHT + 10, -1, rst_hit);
    run_frame(rand_cells(), '0, -1, -1, 5 * LAYER + 60, rst_hit);
    check("reset_taken", 64'(rst_hit), 64'h1);

    repeat (3) @(negedge Clk);
    exp_q.delete();
    v = rand_cells();
    bus.Cells = v;
    push_frame(v);
    Reset = 1'b1;
    n = 0;
    while (n < 2 * LIGHT) begin
      @(posedge Clk);
      #1;
      n++;
      if (bus.Layer_en != 8'h00) break;
    end
    check("relight_latency", 64'(n), 64'(LIGHT));
    check("relight_layer_en", 64'(bus.Layer_en), 64'h01);
    repeat (FRAME - n) @(negedge Clk);

    run_frame(rand_cells(), '0, -1, -1, -1, rst_hit);
    repeat (5) @(negedge Clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
